decode_hazard_ctrl: RTL

Scoreboard-based issue controller for the decode stage. It tracks in-flight writes to each of the 8 architectural registers and holds decode while any source register has a pending write. It also stalls when a destination's pending counter is full. It sequences pipeline start-up after reset and draining on HALT.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/reg_pending_cnt.sv | 69 ++++++
 rtl/decode_hazard_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the decode-stage hazard controller:
//   - scoreboard geometry (register count, select width, counter width)
//   - controller state encoding
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int NREGS = 8;   // architectural registers
    localparam int REG_W = 3;   // register select width
    localparam int CNT_W = 2;   // pending-write counter width

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

endpackage

// File: rtl/reg_pending_cnt.sv
// ----------------------------------------------------------------------------
// reg_pending_cnt
// Pending-write counter for one architectural register.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_inc          a new writer to this register issues this cycle
//   i_dec1         writeback retires a write to this register this cycle
//   i_dec2         execute squashes a write to this register this cycle
//   o_busy         registered count is nonzero
//   o_eff_zero     count after this cycle's retires/kills is zero
//   o_eff_full     count after this cycle's retires/kills is at maximum
//   o_underflow    decrements this cycle exceed count + increment
//
// The eff flags deliberately ignore i_inc: the increment depends on issue,
// which depends on these flags, so including it would form a loop.
// ----------------------------------------------------------------------------
module reg_pending_cnt
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_dec1,
    input  logic i_dec2,
    output logic o_busy,
    output logic o_eff_zero,
    output logic o_eff_full,
    output logic o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_cnt_ext;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_dec;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W-1:0] w_next;

    assign w_cnt_ext = {1'b0, r_cnt};
    assign w_sum     = w_cnt_ext + {{CNT_W{1'b0}}, i_inc};
    assign w_dec     = {{CNT_W{1'b0}}, i_dec1} + {{CNT_W{1'b0}}, i_dec2};
    assign w_diff    = w_sum - w_dec;

    assign o_underflow = (w_sum < w_dec);

    // Clamp to zero on underflow; saturate at the top for robustness even
    // though the full-stall keeps an increment away from a full counter.
    always_comb begin
        w_next = w_diff[CNT_W-1:0];
        if (o_underflow) begin
            w_next = '0;
        end else if (w_diff[CNT_W]) begin
            w_next = CNT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_busy     = (r_cnt != '0);
    assign o_eff_zero = (w_cnt_ext <= w_dec);
    assign o_eff_full = (r_cnt == CNT_MAX) && (w_dec == '0);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// decode_hazard_ctrl
// Scoreboard issue controller for the decode stage. Counts in-flight writes
// per register, stalls decode on RAW hazards and full counters, sequences
// start-up after reset and draining after HALT.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid                 decode holds a valid instruction
//   id_rs1/_used, id_rs2/_used  source selects and read enables
//   id_wr, id_wr_reg         instruction writes id_wr_reg
//   id_halt                  instruction is HALT
//   wb_wr, wb_reg            writeback retires a write this cycle
//   ex_kill, ex_kill_reg     a squashed execute instruction had a write
//   stall                    hold PC and IF/ID latch
//   issue                    decode instruction advances this cycle
//   busy_mask                per-register pending count nonzero (registered)
//   halted                   pipeline drained after HALT
//   err                      sticky counter underflow
//   dbg_state                controller state, for observation
//
// Handshake: the decode instruction is consumed at a rising edge exactly when
// issue=1 (id_valid=1 and no stall in RUN); otherwise it must be held.
// ----------------------------------------------------------------------------
module decode_hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic             id_wr,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_halt,
    input  logic             wb_wr,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             ex_kill,
    input  logic [REG_W-1:0] ex_kill_reg,
    output logic             stall,
    output logic             issue,
    output logic [NREGS-1:0] busy_mask,
    output logic             halted,
    output logic             err,
    output logic [1:0]       dbg_state
);

    state_t r_state;
    state_t w_state_nxt;

    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_wb_dec;
    logic [NREGS-1:0] w_kill_dec;
    logic [NREGS-1:0] w_eff_zero;
    logic [NREGS-1:0] w_eff_full;
    logic [NREGS-1:0] w_uflow;
    logic             w_hazard;
    logic             r_err;

    // ---------------- per-register pending counters ----------------
    for (genvar g = 0; g < NREGS; g++) begin : g_cnt
        assign w_inc[g]      = issue & id_wr & (id_wr_reg == REG_W'(g));
        assign w_wb_dec[g]   = wb_wr & (wb_reg == REG_W'(g));
        assign w_kill_dec[g] = ex_kill & (ex_kill_reg == REG_W'(g));

        reg_pending_cnt u_cnt (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_inc       (w_inc[g]),
            .i_dec1      (w_wb_dec[g]),
            .i_dec2      (w_kill_dec[g]),
            .o_busy      (busy_mask[g]),
            .o_eff_zero  (w_eff_zero[g]),
            .o_eff_full  (w_eff_full[g]),
            .o_underflow (w_uflow[g])
        );
    end

    // Same-cycle retires are bypassed by the register file, so hazards are
    // judged on the effective (post-retire) counts.
    assign w_hazard = (id_rs1_used & ~w_eff_zero[id_rs1])
                    | (id_rs2_used & ~w_eff_zero[id_rs2])
                    | (id_wr       &  w_eff_full[id_wr_reg]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = RUN;
            RUN:     if (issue && id_halt) w_state_nxt = DRAIN;
            // busy_mask is the registered count, so HALTED follows the
            // cycle in which every counter reads zero.
            DRAIN:   if (busy_mask == '0) w_state_nxt = HALTED;
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall  = 1'b1;
        issue  = 1'b0;
        halted = 1'b0;
        case (r_state)
            RUN: begin
                stall = id_valid & w_hazard;
                issue = id_valid & ~w_hazard;
            end
            HALTED:  halted = 1'b1;
            default: ;
        endcase
    end

    // ---------------- sticky underflow flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (|w_uflow) begin
            r_err <= 1'b1;
        end
    end

    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
